stream_serializer: RTL and testbench
====================================

Name: stream_serializer

Overview:
Parallel-in/serial-out unloader: accepts one word of NumBeats elements on a valid/ready input handshake and emits the elements one per handshake on a valid/ready output stream, element 0 first. It is the unload end of the element-wise shift chains used in the datapath: a wide word produced in one cycle is drained element-by-element toward narrow consumers. Supports a synchronous clear and back-to-back words with no bubble cycle.

Parameters:
dtype, logic [7:0], element type; any packed type.
NumBeats, 4, elements per input word; must be >= 1, 0 is an elaboration error ($error).

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  reset; one clock; reset is synchronous and active-low
clr_i  input  1  synchronous clear; drops any word in flight
data_i  input  NumBeats*$bits(dtype)  input word, element k at data_i[k]
valid_i  input  1  input word valid
ready_o  output  1  block can accept a word this cycle
data_o  output  $bits(dtype)  current output element
valid_o  output  1  data_o valid
ready_i  input  1  downstream accepts data_o
last_o  output  1  only with STREAM_SERIALIZER_LAST_EN; marks final element of a word

Behaviour:
- State: FSM {IDLE, SHIFT}; word buffer buf_q[NumBeats] of dtype; beat counter cnt_q, width max(1,$clog2(NumBeats)).
- Reset (rst_ni low at a clock edge): state IDLE, cnt_q 0, buf_q all '0. Outputs after reset: valid_o 0, data_o '0, ready_o 1, last_o 0.
- IDLE: valid_o 0, data_o '0, ready_o 1 (unless clr_i). On valid_i && ready_o: buf_q <= data_i, cnt_q <= 0, go SHIFT.
- SHIFT: valid_o 1, data_o = buf_q[cnt_q].
  - ready_i 0: hold; data_o, valid_o stable (AXI-style: no retraction, no change while stalled).
  - ready_i 1 and cnt_q < NumBeats-1: cnt_q increments.
  - ready_i 1 and cnt_q == NumBeats-1 (last beat): if valid_i, load new word, cnt_q <= 0, stay SHIFT (no bubble); otherwise go IDLE.
- ready_o = (state==IDLE) || (state==SHIFT && cnt_q==NumBeats-1 && ready_i), gated by !clr_i. Combinational ready_i -> ready_o path is intentional and documented.
- Latency: first element is visible on data_o the cycle after input handshake. Throughput: one element per cycle under full ready_i; one word per NumBeats cycles sustained.
- NumBeats == 1: every word is its own last beat; degenerates to a one-entry valid/ready register with a full-throughput pass-through.
- clr_i (synchronous, priority below rst_ni, above all else): at the edge, state IDLE, cnt_q 0, buf_q contents are don't-care but data_o is forced '0 in IDLE. While clr_i is high: ready_o 0, no input accepted. valid_o goes 0 the cycle after the clear edge, even mid-stall.
- Reset or clear mid-word: remaining elements are discarded; no partial output afterwards.
- valid_i with ready_o 0: no effect; upstream must hold data_i.

Optional Feature:
STREAM_SERIALIZER_LAST_EN defined: adds port last_o = valid_o && (cnt_q == NumBeats-1); reset value 0; for NumBeats 1, last_o = valid_o.
Not defined: port last_o absent; no other behavioural change.

Test Plan:
- Reset: rst_ni low 2 cycles with valid_i 1 -> valid_o 0, data_o 0x00, ready_o 1 after release; no word captured.
- Single word: dtype logic[7:0], NumBeats 4, data_i 0x44332211 handshake at cycle 0, ready_i 1 -> data_o 0x11,0x22,0x33,0x44 in cycles 1-4; ready_o 0 in cycles 1-3, 1 in cycle 4; valid_o 0 in cycle 5.
- Back-to-back: second word 0x88776655 held valid from cycle 1 -> accepted in cycle 4; data_o 0x55 in cycle 5, with no idle cycle between 0x44 and 0x55.
- Backpressure: ready_i 0 for cycles 2-4 of the first word -> data_o holds 0x22 with valid_o 1 for those cycles; sequence resumes 0x33,0x44; total 7 beat cycles.
- Clear mid-word: clr_i pulsed in cycle 2 (data_o 0x22) -> cycle 3 valid_o 0, ready_o 1; next word 0xDDCCBBAA emits 0xAA first.
- With STREAM_SERIALIZER_LAST_EN: last_o is 1 only alongside 0x44 and 0x88. With NumBeats 1, words 0x01,0x02 back-to-back stream at one per cycle with last_o 1 on each.

Source files
------------

// File: rtl/stream_serializer.sv
// Parallel-in/serial-out unloader: takes one word of NumBeats elements on the
// input handshake and drains it element 0 first, one element per output handshake.
// Back-to-back words are accepted on the last beat, so no bubble cycle is inserted.
// Optional feature: define STREAM_SERIALIZER_LAST_EN to add the last_o port.
module stream_serializer #(
    parameter type         dtype    = logic [7:0],
    parameter int unsigned NumBeats = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clr_i,
    input  logic [NumBeats*$bits(dtype)-1:0] data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output dtype                           data_o,
    output logic                           valid_o,
    input  logic                           ready_i
`ifdef STREAM_SERIALIZER_LAST_EN
    ,
    output logic                           last_o
`endif
);

    localparam int unsigned ElemW = $bits(dtype);
    localparam int unsigned CntW  = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumBeats - 1);

    if (NumBeats < 1) begin : gen_bad_beats
        $error("stream_serializer: NumBeats must be >= 1");
    end

    typedef enum logic {StIdle, StShift} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    dtype            buf_q [NumBeats];
    dtype            buf_d [NumBeats];
    logic            last_beat;
    logic            accept;

    assign last_beat = (cnt_q == LastCnt);

    // Next-state, handshake and output decode.
    // ready_o depends combinationally on ready_i: a new word is taken in the same
    // cycle the final element leaves, which is what removes the bubble.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        data_o  = '0;

        if (!clr_i) begin
            ready_o = (state_q == StIdle) || (state_q == StShift && last_beat && ready_i);
        end
        accept = valid_i && ready_o;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                valid_o = 1'b1;
                data_o  = buf_q[cnt_q];
                if (ready_i) begin
                    if (!last_beat) begin
                        cnt_d = cnt_q + CntW'(1);
                    end else if (accept) begin
                        cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            for (int k = 0; k < NumBeats; k++) begin
                buf_d[k] = dtype'(data_i[k*ElemW +: ElemW]);
            end
        end

        // Clear drops the word in flight; buffer contents are left as they are
        // since data_o is forced to zero in StIdle.
        if (clr_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

`ifdef STREAM_SERIALIZER_LAST_EN
    // Marks the final element of the word currently on the output.
    always_comb begin
        last_o = valid_o && last_beat;
    end
`endif

    // State, counter and buffer registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            for (int k = 0; k < NumBeats; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer (NumBeats 4 and NumBeats 1 instances).
// Expected elements are queued at stimulus time; monitors pop on each output handshake.
module tb_stream_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [31:0] a_data_i;
    logic        a_valid_i, a_ready_o, a_valid_o, a_ready_i;
    logic [7:0]  a_data_o;
    logic [7:0]  b_data_i;
    logic        b_valid_i, b_ready_o, b_valid_o, b_ready_i;
    logic [7:0]  b_data_o;
`ifdef STREAM_SERIALIZER_LAST_EN
    logic        a_last_o, b_last_o;
`endif

    int total = 0;
    int bad   = 0;

    // {last, data}
    logic [8:0] qa [$];
    logic [8:0] qb [$];

    always #5 clk = ~clk;

    stream_serializer #(.dtype(logic [7:0]), .NumBeats(4)) u_dut_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (clr),
        .data_i  (a_data_i),
        .valid_i (a_valid_i),
        .ready_o (a_ready_o),
        .data_o  (a_data_o),
        .valid_o (a_valid_o),
        .ready_i (a_ready_i)
`ifdef STREAM_SERIALIZER_LAST_EN
        ,
        .last_o  (a_last_o)
`endif
    );

    stream_serializer #(.dtype(logic [7:0]), .NumBeats(1)) u_dut_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (1'b0),
        .data_i  (b_data_i),
        .valid_i (b_valid_i),
        .ready_o (b_ready_o),
        .data_o  (b_data_o),
        .valid_o (b_valid_o),
        .ready_i (b_ready_i)
`ifdef STREAM_SERIALIZER_LAST_EN
        ,
        .last_o  (b_last_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic push_a(input logic [7:0] d, input logic last);
        qa.push_back({last, d});
    endtask

    // Monitor for the NumBeats 4 instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && a_valid_o === 1'b1 && a_ready_i === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_beat", {24'h0, a_data_o}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = qa.pop_front();
                chk("a_data", {24'h0, a_data_o}, {24'h0, e[7:0]});
`ifdef STREAM_SERIALIZER_LAST_EN
                chk("a_last", {31'h0, a_last_o}, {31'h0, e[8]});
`endif
            end
        end
    end

    // Monitor for the NumBeats 1 instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && b_valid_o === 1'b1 && b_ready_i === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_beat", {24'h0, b_data_o}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = qb.pop_front();
                chk("b_data", {24'h0, b_data_o}, {24'h0, e[7:0]});
`ifdef STREAM_SERIALIZER_LAST_EN
                chk("b_last", {31'h0, b_last_o}, {31'h0, e[8]});
`endif
            end
        end
    end

    initial begin
        int beats;
        rst_n     = 1'b0;
        clr       = 1'b0;
        a_data_i  = 32'hDEAD_BEEF;
        a_valid_i = 1'b1;
        a_ready_i = 1'b1;
        b_data_i  = 8'h00;
        b_valid_i = 1'b0;
        b_ready_i = 1'b1;

        // Reset with valid_i held high: nothing may be captured.
        cyc();
        cyc();
        rst_n     = 1'b1;
        a_valid_i = 1'b0;
        samp();
        chk("rst_valid_o", {31'h0, a_valid_o}, 32'h0);
        chk("rst_data_o",  {24'h0, a_data_o},  32'h0);
        chk("rst_ready_o", {31'h0, a_ready_o}, 32'h1);
`ifdef STREAM_SERIALIZER_LAST_EN
        chk("rst_last_o",  {31'h0, a_last_o},  32'h0);
`endif
        cyc();
        samp();
        chk("rst_no_capture", {31'h0, a_valid_o}, 32'h0);
        cyc();

        // Single word.
        a_data_i  = 32'h4433_2211;
        a_valid_i = 1'b1;
        push_a(8'h11, 0); push_a(8'h22, 0); push_a(8'h33, 0); push_a(8'h44, 1);
        samp();
        chk("single_ready_c0", {31'h0, a_ready_o}, 32'h1);
        cyc();
        a_valid_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            samp();
            chk("single_ready", {31'h0, a_ready_o}, (c == 4) ? 32'h1 : 32'h0);
            cyc();
        end
        samp();
        chk("single_idle_c5", {31'h0, a_valid_o}, 32'h0);
        cyc();

        // Back-to-back words, no idle cycle between 0x44 and 0x55.
        a_data_i  = 32'h4433_2211;
        a_valid_i = 1'b1;
        push_a(8'h11, 0); push_a(8'h22, 0); push_a(8'h33, 0); push_a(8'h44, 1);
        push_a(8'h55, 0); push_a(8'h66, 0); push_a(8'h77, 0); push_a(8'h88, 1);
        samp();
        cyc();
        a_data_i = 32'h8877_6655;
        for (int c = 1; c <= 8; c++) begin
            samp();
            chk("b2b_valid", {31'h0, a_valid_o}, 32'h1);
            if (c == 4 || c == 8) chk("b2b_ready", {31'h0, a_ready_o}, 32'h1);
            if (c == 5) chk("b2b_first_of_second", {24'h0, a_data_o}, 32'h55);
            cyc();
            if (c == 4) a_valid_i = 1'b0;
        end
        samp();
        chk("b2b_idle", {31'h0, a_valid_o}, 32'h0);
        cyc();

        // Backpressure on cycles 2-4.
        a_data_i  = 32'h4433_2211;
        a_valid_i = 1'b1;
        push_a(8'h11, 0); push_a(8'h22, 0); push_a(8'h33, 0); push_a(8'h44, 1);
        samp();
        cyc();
        a_valid_i = 1'b0;
        beats = 0;
        for (int c = 1; c <= 8; c++) begin
            a_ready_i = !(c >= 2 && c <= 4);
            samp();
            if (a_valid_o === 1'b1) beats++;
            if (c >= 2 && c <= 4) begin
                chk("bp_hold_data",  {24'h0, a_data_o},  32'h22);
                chk("bp_hold_valid", {31'h0, a_valid_o}, 32'h1);
            end
            cyc();
        end
        a_ready_i = 1'b1;
        chk("bp_beat_cycles", beats, 32'd7);

        // Clear mid-word at the 0x22 beat.
        a_data_i  = 32'h4433_2211;
        a_valid_i = 1'b1;
        push_a(8'h11, 0); push_a(8'h22, 0);
        samp();
        cyc();
        a_valid_i = 1'b0;
        samp();
        cyc();
        clr = 1'b1;
        samp();
        chk("clr_data_c2",  {24'h0, a_data_o},  32'h22);
        chk("clr_ready_c2", {31'h0, a_ready_o}, 32'h0);
        cyc();
        clr       = 1'b0;
        a_data_i  = 32'hDDCC_BBAA;
        a_valid_i = 1'b1;
        push_a(8'hAA, 0); push_a(8'hBB, 0); push_a(8'hCC, 0); push_a(8'hDD, 1);
        samp();
        chk("clr_valid_c3", {31'h0, a_valid_o}, 32'h0);
        chk("clr_ready_c3", {31'h0, a_ready_o}, 32'h1);
        chk("clr_data_c3",  {24'h0, a_data_o},  32'h0);
        cyc();
        a_valid_i = 1'b0;
        samp();
        chk("clr_next_first", {24'h0, a_data_o}, 32'hAA);
        for (int c = 0; c < 4; c++) cyc();
        samp();
        chk("clr_drained_idle", {31'h0, a_valid_o}, 32'h0);
        cyc();

        // NumBeats 1: back-to-back words at one per cycle.
        b_data_i  = 8'h01;
        b_valid_i = 1'b1;
        qb.push_back({1'b1, 8'h01});
        qb.push_back({1'b1, 8'h02});
        samp();
        chk("nb1_ready_c0", {31'h0, b_ready_o}, 32'h1);
        cyc();
        b_data_i = 8'h02;
        samp();
        chk("nb1_valid_c1", {31'h0, b_valid_o}, 32'h1);
        chk("nb1_ready_c1", {31'h0, b_ready_o}, 32'h1);
        cyc();
        b_valid_i = 1'b0;
        samp();
        chk("nb1_valid_c2", {31'h0, b_valid_o}, 32'h1);
        chk("nb1_data_c2",  {24'h0, b_data_o},  32'h02);
        cyc();
        samp();
        chk("nb1_idle_c3", {31'h0, b_valid_o}, 32'h0);
        cyc();

        // Everything queued must have been seen.
        chk("qa_empty", qa.size(), 32'd0);
        chk("qb_empty", qb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
